// File: rtl/nand_reduce_pipe.sv
// Pipelined wide NAND/AND/NOR/OR reducer: a binary tree of 2-input gates with
// one register level per tree level, valid/ready on both sides and a result counter.
module nand_reduce_pipe #(
  parameter int N_IN  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  i,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             y,
  output logic [1:0]       out_mode,
  output logic [CNT_W-1:0] result_count
);

  localparam int LEVELS = $clog2(N_IN);
  // All tree levels packed back to back: level 1 in the low bits, the final
  // single-bit result in the top bit. Widths N_IN/2 + N_IN/4 + ... + 1 = N_IN-1.
  localparam int TREE_W = N_IN - 1;

  if (N_IN < 2 || N_IN > 64 || (N_IN & (N_IN - 1)) != 0) begin : g_cfgCheck
    $error("nand_reduce_pipe: N_IN=%0d must be a power of two from 2 to 64", N_IN);
  end

  logic [TREE_W-1:0]      tree_q;
  logic [TREE_W-1:0]      tree_d;
  logic [LEVELS-1:0][1:0] mode_q;
  logic [LEVELS-1:0]      valid_q;
  logic [CNT_W-1:0]       count_q;
  logic [CNT_W-1:0]       count_d;

  logic                   stall;
  logic                   inFire;
  logic                   outFire;

  // Source of every level: the input port for level 1, the previous register
  // level otherwise. Index l of each chain feeds register level l (0-based).
  logic [2*N_IN-3:0]      dataChain;
  logic [LEVELS-1:0][1:0] modeChain;
  logic [LEVELS-1:0]      validChain;

  assign out_valid    = valid_q[LEVELS-1];
  assign y            = tree_q[TREE_W-1];
  assign out_mode     = mode_q[LEVELS-1];
  assign result_count = count_q;

  assign stall    = out_valid && !out_ready;
  assign in_ready = rst_n && !stall;
  assign inFire   = in_valid && in_ready;
  assign outFire  = out_valid && out_ready;

  if (LEVELS == 1) begin : g_chain
    assign dataChain  = i;
    assign modeChain  = mode;
    assign validChain = inFire;
  end else begin : g_chain
    assign dataChain  = {tree_q[TREE_W-2:0], i};
    assign modeChain  = {mode_q[LEVELS-2:0], mode};
    assign validChain = {valid_q[LEVELS-2:0], inFire};
  end

  // Pairwise reduction for every level using the mode that travels with the
  // data into that level; the NAND/NOR inversion happens only at the last level.
  always_comb begin
    tree_d = '0;
    for (int l = 0; l < LEVELS; l++) begin
      for (int p = 0; p < (N_IN >> (l + 1)); p++) begin
        if (modeChain[l][1]) begin
          tree_d[N_IN - 2*(N_IN >> (l + 1)) + p] =
            dataChain[2*N_IN - 2*(N_IN >> l) + 2*p] |
            dataChain[2*N_IN - 2*(N_IN >> l) + 2*p + 1];
        end else begin
          tree_d[N_IN - 2*(N_IN >> (l + 1)) + p] =
            dataChain[2*N_IN - 2*(N_IN >> l) + 2*p] &
            dataChain[2*N_IN - 2*(N_IN >> l) + 2*p + 1];
        end
      end
    end
    tree_d[TREE_W-1] = tree_d[TREE_W-1] ^ ~modeChain[LEVELS-1][0];
  end

  always_comb begin
    count_d = count_q;
    if (outFire) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // A stall freezes every level at once, so bubbles are never squeezed out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tree_q  <= '0;
      mode_q  <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      if (!stall) begin
        tree_q  <= tree_d;
        mode_q  <= modeChain;
        valid_q <= validChain;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: doc/nand_reduce_pipe.md
Name: nand_reduce_pipe

Overview:
- Parametrised, pipelined successor to the 4-input NAND built from 2-input NANDs.
- Reduces an N_IN-bit vector through a binary tree of 2-input gates, with one register level per tree level.
- Supports four reduction modes and valid/ready handshakes on both sides.
- Counts delivered results; used as a streaming wide-gate evaluator between producer and consumer blocks.

Parameters:
- N_IN, 8, input vector width; power of two, 2 to 64.
- CNT_W, 8, width of the delivered-result counter.
- LEVELS, log2(N_IN) (derived, localparam), number of tree and pipeline levels.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  i and mode are valid this cycle.
- in_ready  output  1  pipeline can accept this cycle.
- i  input  N_IN  operand vector.
- mode  input  2  00 NAND, 01 AND, 10 NOR, 11 OR.
- out_valid  output  1  y is valid.
- out_ready  input  1  consumer accepts y.
- y  output  1  reduction result.
- out_mode  output  2  mode that produced y.
- result_count  output  CNT_W  number of results accepted by the consumer, modulo 2^CNT_W.

Behaviour:
- Reset is synchronous on the rising clk edge with rst_n=0.
  - All stage valid bits cleared; out_valid=0, y=0, out_mode=00, result_count=0.
  - in_ready=0 while rst_n=0; in_ready=1 in the first cycle after release.
- Function, where R = reduction over all N_IN bits:
  - NAND: y = ~&i.
  - AND: y = &i.
  - NOR: y = ~|i.
  - OR: y = |i.
- Tree structure:
  - Level k (1..LEVELS) registers N_IN>>k partial terms.
  - Each partial term is an AND of adjacent pairs (modes 00/01) or an OR of adjacent pairs (modes 10/11).
  - The final inversion for NAND/NOR is applied when loading the last stage.
  - mode is carried alongside the data in every stage register; the tree never mixes modes between stages.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = rst_n && !stall.
  - While stall=1, every stage register holds, including y and out_mode.
  - No bubble collapsing.
- Latency:
  - A transfer accepted at edge t gives out_valid=1 after edge t+LEVELS−1, i.e. y is visible LEVELS cycles after acceptance when no stall occurs.
  - N_IN=8 gives 3 cycles; N_IN=2 gives 1 cycle.
- Throughput: one result per cycle with out_ready held at 1.
- Bubbles: cycles with no input transfer advance a valid=0 token; y and out_mode may hold any value while out_valid=0.
- Counter: result_count increments by 1 on each output transfer and wraps from 2^CNT_W−1 to 0.
- Simultaneous events:
  - An input transfer and an output transfer in the same cycle are both taken.
  - The pipeline shifts and the count increments in that cycle.
- Reset mid-operation:
  - All in-flight results are discarded (valid bits cleared) and result_count returns to 0.
  - No out_valid appears for inputs accepted before the reset.
- Unsupported configuration: N_IN not a power of two or outside 2 to 64 is a configuration error, flagged by a simulation-time check at elaboration.

Test Plan:
- Exhaustive sweep, N_IN=8, mode=00, i=0x00..0xFF streamed with out_ready=1.
  - Expect y=1 for all inputs except i=0xFF, which gives y=0.
  - First out_valid 3 cycles after first acceptance; 256 consecutive results; result_count=0 after wrap (CNT_W=8).
- Mode check, N_IN=8, i=0xFF, then 0x00, then 0x10, each in every mode:
  - AND gives 1/0/0.
  - NAND gives 0/1/1.
  - OR gives 1/0/1.
  - NOR gives 0/1/0.
  - out_mode echoes each mode.
- Backpressure: stream 4 inputs, drop out_ready for 5 cycles at the first out_valid.
  - in_ready=0 throughout; y and out_mode stable.
  - After release, 4 results appear in order, none lost or duplicated; result_count=4.
- Reset mid-flight: accept 2 inputs, assert rst_n=0 for 1 cycle one edge later.
  - Expect out_valid=0 and result_count=0 afterwards, with no stale result.
  - A new input yields exactly one result 3 cycles later.
- Minimum configuration, N_IN=2, mode=00, i=00/01/10/11 → y=1/1/1/0 with 1-cycle latency.
- Wide configuration, N_IN=64, mode=01:
  - i all ones → y=1.
  - Single zero bit at bit 37 → y=0.
  - Latency 6 cycles.
